// File: rtl/lbi_pkg.sv
// Shared constants and types for the LBI chunk protocol (transmit side and Lbirow array).
package lbi_pkg;
  localparam int INPUTSIZE = 840;
  localparam int CHUNK_W   = 16;
  localparam int NUM_CHUNK = (INPUTSIZE + CHUNK_W - 1) / CHUNK_W;
  localparam int PAD_W     = NUM_CHUNK * CHUNK_W - INPUTSIZE;
  localparam int CIDX_W    = $clog2(NUM_CHUNK);

  localparam logic [CIDX_W-1:0] LAST_IDX = CIDX_W'(NUM_CHUNK - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_t;
endpackage

// File: rtl/lbi_msg_tx_if.sv
// Message-in / chunk-out bundle for lbi_msg_tx. chunk_par exists only with LBI_MSG_TX_PARITY_EN.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high;
// valid never depends on ready, and the transmitter holds its chunk outputs while ready is low.
interface lbi_msg_tx_if;
  import lbi_pkg::*;

  logic [2*INPUTSIZE-1:0] msg_in;
  logic                   msg_in_vld;
  logic                   msg_in_rdy;
  logic [CHUNK_W-1:0]     chunk_left;
  logic [CHUNK_W-1:0]     chunk_right;
  logic [CIDX_W-1:0]      chunk_idx;
  logic                   chunk_first;
  logic                   chunk_last;
  logic                   chunk_vld;
  logic                   chunk_rdy;
  logic                   busy;
`ifdef LBI_MSG_TX_PARITY_EN
  logic [1:0]             chunk_par;
`endif

  // master: the transmitter itself
  modport master (
    input  msg_in, msg_in_vld, chunk_rdy,
    output msg_in_rdy, chunk_left, chunk_right, chunk_idx,
           chunk_first, chunk_last, chunk_vld, busy
`ifdef LBI_MSG_TX_PARITY_EN
    , output chunk_par
`endif
  );

  // slave: the message source plus the Lbirow side
  modport slave (
    output msg_in, msg_in_vld, chunk_rdy,
    input  msg_in_rdy, chunk_left, chunk_right, chunk_idx,
           chunk_first, chunk_last, chunk_vld, busy
`ifdef LBI_MSG_TX_PARITY_EN
    , input chunk_par
`endif
  );
endinterface

// File: rtl/lbi_chunk_sel.sv
// Zero-pads one message half up to a whole number of chunks and selects chunk idx.
// Purely combinational; an out-of-range idx yields zero.
module lbi_chunk_sel #(
  parameter  int INPUTSIZE = lbi_pkg::INPUTSIZE,
  parameter  int CHUNK_W   = lbi_pkg::CHUNK_W,
  localparam int NUM_CHUNK = (INPUTSIZE + CHUNK_W - 1) / CHUNK_W,
  localparam int CIDX_W    = $clog2(NUM_CHUNK)
) (
  input  logic [INPUTSIZE-1:0] half,
  input  logic [CIDX_W-1:0]    idx,
  output logic [CHUNK_W-1:0]   chunk
);
  logic [NUM_CHUNK*CHUNK_W-1:0] padded;

  // zero-extension puts the pad bits above the top half bit
  assign padded = (NUM_CHUNK*CHUNK_W)'(half);

  always_comb begin
    chunk = '0;
    for (int i = 0; i < NUM_CHUNK; i++) begin
      if (idx == CIDX_W'(i)) chunk = padded[i*CHUNK_W +: CHUNK_W];
    end
  end
endmodule

// File: rtl/lbi_msg_tx.sv
// LBI chunk transmitter: holds one 2*INPUTSIZE message and streams it as NUM_CHUNK
// left/right chunk pairs. Optional parity output enabled by LBI_MSG_TX_PARITY_EN.
module lbi_msg_tx
  import lbi_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  lbi_msg_tx_if.master bus,
  output tx_state_t    dbg_state
);
  tx_state_t              state_q, state_d;
  logic [CIDX_W-1:0]      idx_q, idx_d;
  logic [2*INPUTSIZE-1:0] msg_q, msg_d;
  logic                   at_last;

  assign at_last = (idx_q == LAST_IDX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      msg_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      msg_q   <= msg_d;
    end
  end

  // msg_in_rdy is exactly (state_q == IDLE), so IDLE & vld is the capture handshake
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    msg_d   = msg_q;
    case (state_q)
      IDLE: begin
        if (bus.msg_in_vld) begin
          state_d = SEND;
          msg_d   = bus.msg_in;
          idx_d   = '0;
        end
      end
      SEND: begin
        if (bus.chunk_rdy) begin
          if (at_last) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + CIDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // every output below depends only on state_q/idx_q/msg_q
  always_comb begin
    bus.msg_in_rdy  = (state_q == IDLE);
    bus.chunk_vld   = (state_q == SEND);
    bus.busy        = (state_q == SEND);
    bus.chunk_idx   = idx_q;
    bus.chunk_first = (state_q == SEND) && (idx_q == '0);
    bus.chunk_last  = (state_q == SEND) && at_last;
    dbg_state       = state_q;
  end

  lbi_chunk_sel #(.INPUTSIZE(INPUTSIZE), .CHUNK_W(CHUNK_W)) u_sel_left (
    .half  (msg_q[2*INPUTSIZE-1:INPUTSIZE]),
    .idx   (idx_q),
    .chunk (bus.chunk_left)
  );

  lbi_chunk_sel #(.INPUTSIZE(INPUTSIZE), .CHUNK_W(CHUNK_W)) u_sel_right (
    .half  (msg_q[INPUTSIZE-1:0]),
    .idx   (idx_q),
    .chunk (bus.chunk_right)
  );

`ifdef LBI_MSG_TX_PARITY_EN
  // even parity over the chunk pair, forced to 0 whenever no chunk is presented
  assign bus.chunk_par = (state_q == SEND) ? {^bus.chunk_left, ^bus.chunk_right} : 2'b00;
`endif
endmodule
